// File: rtl/prism_sp_pkg.sv
// Shared prism_sp definitions: system address width, cookie tag width and
// the default-geometry converted cookie layout.
package prism_sp_pkg;

    localparam int unsigned SYSTEM_ADDR_WIDTH    = 32;
    localparam int unsigned COOKIE_TAG_WIDTH     = 8;
    localparam int unsigned COOKIE_INDEX_WIDTH   = 10;
    localparam int unsigned COOKIE_PAYLOAD_WIDTH = 14;

    // Layout of data_out for the default DATA_OUT_WIDTH=32 / INDEX_WIDTH=10 build.
    typedef struct packed {
        logic [COOKIE_TAG_WIDTH-1:0]     tag;
        logic [COOKIE_INDEX_WIDTH-1:0]   index;
        logic [COOKIE_PAYLOAD_WIDTH-1:0] payload;
    } cookie_out_t;

endpackage

// File: rtl/prism_sp_skid_buffer.sv
// Valid/ready skid buffer: a bypass path plus one skid register, with a
// registered up_ready so the upstream never sees a combinational ready path.
module prism_sp_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             ready_q;
    logic             skid_valid_q;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_q;
    logic             accept;

    assign up_ready = ready_q;
    assign accept   = up_valid && ready_q;
    assign dn_valid = skid_valid_q || accept;
    assign dn_data  = skid_valid_q ? skid_data_q : up_data;

    // ready_q mirrors !skid_valid, so accept and a full skid never coincide.
    always_comb begin
        skid_valid_d = skid_valid_q;
        if (skid_valid_q && dn_ready) begin
            skid_valid_d = 1'b0;
        end else if (accept && !dn_ready) begin
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            ready_q      <= !skid_valid_d;
            skid_valid_q <= skid_valid_d;
            if (accept && !dn_ready) begin
                skid_data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/prism_sp_ring_cookie_converter.sv
// Converts raw ring cookies into {tag, descriptor index, payload} with range and
// alignment checking. Optional sequence tag counter: PRISM_SP_COOKIE_SEQ_TAG_EN.
module prism_sp_ring_cookie_converter
    import prism_sp_pkg::*;
#(
    parameter int unsigned DATA_IN_WIDTH  = 64,
    parameter int unsigned DATA_OUT_WIDTH = 32,
    parameter int unsigned INDEX_WIDTH    = 10,
    parameter int unsigned DESC_SHIFT     = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SYSTEM_ADDR_WIDTH-1:0] ring_base,
    input  logic [INDEX_WIDTH:0]         ring_size,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_IN_WIDTH-1:0]     data_in,
    input  logic [SYSTEM_ADDR_WIDTH-1:0] dma_desc_cur,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_OUT_WIDTH-1:0]    data_out,
    output logic                         out_error
);

    localparam int unsigned PAYLOAD_WIDTH = DATA_OUT_WIDTH - COOKIE_TAG_WIDTH - INDEX_WIDTH;
    localparam int unsigned REQ_WIDTH     = COOKIE_TAG_WIDTH + PAYLOAD_WIDTH + SYSTEM_ADDR_WIDTH;
    localparam logic [SYSTEM_ADDR_WIDTH-1:0] ALIGN_MASK =
        (SYSTEM_ADDR_WIDTH'(1) << DESC_SHIFT) - SYSTEM_ADDR_WIDTH'(1);

    if (DATA_OUT_WIDTH < INDEX_WIDTH + COOKIE_TAG_WIDTH + 1) begin : g_bad_out_width
        $error("DATA_OUT_WIDTH must be at least INDEX_WIDTH + 9");
    end
    if (DATA_IN_WIDTH < PAYLOAD_WIDTH) begin : g_bad_in_width
        $error("DATA_IN_WIDTH too narrow for the converted payload field");
    end

    logic [COOKIE_TAG_WIDTH-1:0] tag;

`ifdef PRISM_SP_COOKIE_SEQ_TAG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag <= '0;
        end else if (in_valid && in_ready) begin
            tag <= tag + COOKIE_TAG_WIDTH'(1);
        end
    end
`else
    assign tag = '0;
`endif

    logic                         sk_valid;
    logic                         s1_ready;
    logic [REQ_WIDTH-1:0]         sk_data;
    logic [COOKIE_TAG_WIDTH-1:0]  sk_tag;
    logic [PAYLOAD_WIDTH-1:0]     sk_payload;
    logic [SYSTEM_ADDR_WIDTH-1:0] sk_desc;

    prism_sp_skid_buffer #(
        .WIDTH (REQ_WIDTH)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  ({tag, data_in[PAYLOAD_WIDTH-1:0], dma_desc_cur}),
        .dn_valid (sk_valid),
        .dn_ready (s1_ready),
        .dn_data  (sk_data)
    );

    assign {sk_tag, sk_payload, sk_desc} = sk_data;

    logic                         s1_valid;
    logic [COOKIE_TAG_WIDTH-1:0]  s1_tag;
    logic [PAYLOAD_WIDTH-1:0]     s1_payload;
    logic [SYSTEM_ADDR_WIDTH-1:0] s1_desc;
    logic [SYSTEM_ADDR_WIDTH-1:0] s1_offset;
    logic                         s2_valid;
    logic                         s2_en;

    // Both stages hold whenever the output is stalled with a response in it.
    assign s2_en    = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_en;

    logic [SYSTEM_ADDR_WIDTH-1:0] s1_slot;
    logic [SYSTEM_ADDR_WIDTH-1:0] ring_size_ext;
    logic [INDEX_WIDTH-1:0]       s1_index;
    logic                         s1_error;

    // Untruncated slot number, so a base above the descriptor wraps to out of range.
    assign s1_slot       = s1_offset >> DESC_SHIFT;
    assign s1_index      = s1_slot[INDEX_WIDTH-1:0];
    assign ring_size_ext = SYSTEM_ADDR_WIDTH'(ring_size);
    assign s1_error      = (ring_size == '0)
                        || ((s1_offset & ALIGN_MASK) != '0)
                        || (s1_slot >= ring_size_ext);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_tag     <= '0;
            s1_payload <= '0;
            s1_desc    <= '0;
            s1_offset  <= '0;
            s2_valid   <= 1'b0;
            data_out   <= '0;
            out_error  <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid <= sk_valid;
                if (sk_valid) begin
                    s1_tag     <= sk_tag;
                    s1_payload <= sk_payload;
                    s1_desc    <= sk_desc;
                    s1_offset  <= sk_desc - ring_base;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    data_out  <= {s1_tag, s1_index, s1_payload};
                    out_error <= s1_error;
                end
            end
        end
    end

    assign out_valid = s2_valid;

    logic unused_bits;
    assign unused_bits = ^{data_in, s1_desc};

endmodule

// File: tb/tb_prism_sp_ring_cookie_converter.sv
// Directed bench for prism_sp_ring_cookie_converter (default parameters),
// with a scoreboard of hand-derived expected cookies.
module tb_prism_sp_ring_cookie_converter;
    import prism_sp_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ring_base = 32'h1000;
    logic [10:0] ring_size = 11'd16;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic [31:0] dma_desc_cur = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic        out_error;

    prism_sp_ring_cookie_converter #(
        .DATA_IN_WIDTH  (64),
        .DATA_OUT_WIDTH (32),
        .INDEX_WIDTH    (10),
        .DESC_SHIFT     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ring_base    (ring_base),
        .ring_size    (ring_size),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .dma_desc_cur (dma_desc_cur),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .out_error    (out_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_resp = 0;
    logic        acc = 1'b0;
    logic [7:0]  tag_m = '0;
    logic [9:0]  nxt_idx = '0;
    logic        nxt_err = 1'b0;
    cookie_out_t c;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_tag();
`ifdef PRISM_SP_COOKIE_SEQ_TAG_EN
        return tag_m;
`else
        return 8'h00;
`endif
    endfunction

    // Sample handshakes on the falling edge, then advance to just past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clock);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_resp++;
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("data_out", 64'(data_out), 64'(e.data));
                chk("out_error", 64'(out_error), 64'(e.err));
            end
        end
        if (acc) begin
            e.data = {exp_tag(), nxt_idx, data_in[13:0]};
            e.err  = nxt_err;
            sb.push_back(e);
            tag_m = tag_m + 8'd1;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [31:0] a,
                        input logic [9:0] idx, input logic err);
        in_valid     = 1'b1;
        data_in      = d;
        dma_desc_cur = a;
        nxt_idx      = idx;
        nxt_err      = err;
        for (int n = 0; n < 64; n++) begin
            cycle();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_out_error", 64'(out_error), 64'd0);
        sb.delete();
        tag_m = '0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("ready_low_pre_edge", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        chk("ready_after_release", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int c0;
        int r0;

        do_reset();

        // Basic conversion and latency
        out_ready = 1'b1;
        send(64'hAB, 32'h1030, 10'd3, 1'b0);
        in_valid = 1'b0;
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        cycle();
        c = cookie_out_t'(data_out);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("r34_index", 64'(c.index), 64'd3);
        chk("r34_payload", 64'(c.payload), 64'hAB);
        chk("r34_tag", 64'(c.tag), 64'd0);
        chk("r34_error", 64'(out_error), 64'd0);
        drain();

        // Range and alignment errors, back to back
        send(64'h11, 32'h0000_0FF0, 10'h3FF, 1'b1);
        send(64'h22, 32'h0000_1100, 10'h010, 1'b1);
        send(64'h33, 32'h0000_1034, 10'h003, 1'b1);
        send(64'h44, 32'h0000_10F0, 10'h00F, 1'b0);
        send(64'h55, 32'h0000_1000, 10'h000, 1'b0);
        send(64'hFFFF_FFFF_FFFF_C123, 32'h0000_1010, 10'h001, 1'b0);
        drain();

        ring_size = 11'd0;
        send(64'h66, 32'h0000_1000, 10'h000, 1'b1);
        drain();

        ring_size = 11'h400;
        send(64'h77, 32'h0000_4FF0, 10'h3FF, 1'b0);
        send(64'h88, 32'h0000_5000, 10'h000, 1'b1);
        drain();

        ring_base = 32'hFFFF_FF00;
        ring_size = 11'd16;
        send(64'h99, 32'h0000_0010, 10'h011, 1'b1);
        send(64'hAA, 32'hFFFF_FF20, 10'h002, 1'b0);
        drain();
        ring_base = 32'h1000;

        // Backpressure from an empty pipeline: three slots fill, then in_ready drops
        out_ready = 1'b0;
        i  = 0;
        r0 = n_resp;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) chk("skid_keeps_ready", 64'(in_ready), 64'd1);
            in_valid     = 1'b1;
            data_in      = 64'hC0DE_0000 + 64'(i);
            dma_desc_cur = 32'h1000 + 32'(16 * i);
            nxt_idx      = 10'(i);
            nxt_err      = 1'b0;
            cycle();
            if (acc) i++;
        end
        chk("stall_accepts", 64'(i), 64'd3);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int n = 0; n < 40 && i < 8; n++) begin
            in_valid     = 1'b1;
            data_in      = 64'hC0DE_0000 + 64'(i);
            dma_desc_cur = 32'h1000 + 32'(16 * i);
            nxt_idx      = 10'(i);
            nxt_err      = 1'b0;
            cycle();
            if (acc) i++;
        end
        chk("bp_all_sent", 64'(i), 64'd8);
        drain();
        chk("bp_responses", 64'(n_resp - r0), 64'd8);

        // 300 back-to-back requests from a fresh tag
        do_reset();
        out_ready = 1'b1;
        c0 = cyc;
        r0 = n_resp;
        i  = 0;
        for (int n = 0; n < 400 && i < 300; n++) begin
            in_valid     = 1'b1;
            data_in      = 64'(i);
            dma_desc_cur = 32'h1000 + 32'(16 * (i % 16));
            nxt_idx      = 10'(i % 16);
            nxt_err      = 1'b0;
            cycle();
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("stream_cycles", 64'(cyc - c0), 64'd300);
        cycle();
        cycle();
        chk("stream_responses", 64'(n_resp - r0), 64'd300);
        drain();

        // Reset while two requests are in flight
        send(64'h1234, 32'h1020, 10'd2, 1'b0);
        send(64'h5678, 32'h1040, 10'd4, 1'b0);
        chk("inflight_valid", 64'(out_valid), 64'd1);
        do_reset();
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        send(64'h0BEE, 32'h1050, 10'd5, 1'b0);
        in_valid = 1'b0;
        cycle();
        c = cookie_out_t'(data_out);
        chk("post_rst_tag", 64'(c.tag), 64'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prism_sp_ring_cookie_converter.md
PRISM_SP_RING_COOKIE_CONVERTER -- requirements
Module: prism_sp_ring_cookie_converter

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 64: raw cookie width from the acquire side.
REQ-002 SHALL have parameter DATA_OUT_WIDTH, default 32: converted cookie width.
REQ-003 SHALL have parameter INDEX_WIDTH, default 10: descriptor index width, i.e. ring holds up to 2^INDEX_WIDTH descriptors.
REQ-004 SHALL have parameter DESC_SHIFT, default 4: log2 of the descriptor size in bytes.
REQ-005 clock  input  1  sole clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 ring_base  input  SYSTEM_ADDR_WIDTH  descriptor ring base address; static while in_valid or out_valid is high.
REQ-008 ring_size  input  INDEX_WIDTH+1  number of descriptors; 0 means empty ring.
REQ-009 in_valid, in_ready  input, output  1 each  request handshake.
REQ-010 data_in  input  DATA_IN_WIDTH  raw cookie; qualified by in_valid.
REQ-011 dma_desc_cur  input  SYSTEM_ADDR_WIDTH  descriptor address; qualified by in_valid.
REQ-012 out_valid, out_ready  output, input  1 each  response handshake.
REQ-013 data_out  output  DATA_OUT_WIDTH  converted cookie; qualified by out_valid.
REQ-014 out_error  output  1  descriptor address is out of range or misaligned; qualified by out_valid.

Function
REQ-015 A transfer SHALL occur on a cycle where valid and ready are both high; the sender holds its payload stable while valid is high and ready is low.
REQ-016 Stage 1 SHALL register data_in, dma_desc_cur, and offset = dma_desc_cur - ring_base, computed as unsigned arithmetic modulo 2^SYSTEM_ADDR_WIDTH.
REQ-017 Stage 2 SHALL form index = offset >> DESC_SHIFT, truncated to INDEX_WIDTH bits.
REQ-018 out_error SHALL be 1 when ring_size == 0, or offset[DESC_SHIFT-1:0] != 0, or (offset >> DESC_SHIFT) >= ring_size; this includes dma_desc_cur < ring_base, which wraps to a large offset.
REQ-019 data_out SHALL be {tag[7:0], index, data_in[DATA_OUT_WIDTH-9-INDEX_WIDTH:0]}; the parameters SHALL satisfy DATA_OUT_WIDTH >= INDEX_WIDTH + 9, checked at elaboration.
REQ-020 The first response SHALL reach out_valid 2 cycles after the accepting edge; with out_ready held high, throughput SHALL be 1 per cycle.
REQ-021 Backpressure SHALL stall both stages; the skid register SHALL keep in_ready high on the first stall cycle; no transfer SHALL be dropped or duplicated.
REQ-022 in_ready SHALL be low only when stage 1, stage 2 and the skid register are all occupied.
REQ-023 tag SHALL be an 8-bit counter that increments once per accepted request and wraps 255 -> 0; the tag is captured at acceptance.
REQ-024 An accept and an output on the same cycle while full SHALL both complete, with no bubble.
REQ-025 Responses SHALL be returned in acceptance order.

Reset
REQ-026 On reset assertion, asynchronously: out_valid=0, in_ready=0, data_out=0, out_error=0, tag=0, and all stages empty.
REQ-027 Transfers in flight when reset is asserted SHALL be discarded.
REQ-028 in_ready SHALL rise on the first clock edge after reset deassertion.

Configuration
REQ-029 With PRISM_SP_COOKIE_SEQ_TAG_EN defined, the tag counter SHALL behave per REQ-023.
REQ-030 Without PRISM_SP_COOKIE_SEQ_TAG_EN, the tag bits SHALL be constant 0 and no counter SHALL be instantiated.

Structure
REQ-031 SYSTEM_ADDR_WIDTH and the constant COOKIE_TAG_WIDTH=8 SHALL come from the shared prism_sp package.
REQ-032 The package SHALL also define a packed struct cookie_out_t {tag, index, payload}.
REQ-033 The stall/skid logic SHALL be one sub-module, prism_sp_skid_buffer, parameterised by payload width.

Verification
REQ-034 ring_base=0x1000, ring_size=16, dma_desc_cur=0x1030, data_in=0xAB, out_ready=1 -> 2 cycles later out_valid=1, index=3, payload=0xAB, out_error=0.
REQ-035 dma_desc_cur=0x0FF0 (below base) or 0x1100 (index 16) or 0x1034 (misaligned) -> out_error=1 for each.
REQ-036 300 back-to-back requests with the tag macro defined -> tags run 0..255, 0..43, and one response per cycle.
REQ-037 out_ready low for 5 cycles during a continuous stream -> in_ready falls after 3 accepts, then all responses arrive in order, none lost.
REQ-038 reset pulsed while 2 requests are in flight -> out_valid=0 immediately, tag=0, and no stale response after release.
REQ-039 macro undefined, 3 requests -> data_out[DATA_OUT_WIDTH-1 -: 8] = 0 for all 3 responses.
